// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel edge-detection datapath.
// Holds the pixel/grayscale widths, the luma coefficients, the saturation
// limit, the pixel typedefs and the RGB-to-gray helper used by the top level.
package sobel_pkg;

  localparam int PIX_W   = 8;    // grayscale / colour channel width
  localparam int GRAD_W  = 11;   // signed gradient width, covers -1020..1020
  localparam int COEF_R  = 77;
  localparam int COEF_G  = 150;
  localparam int COEF_B  = 29;
  localparam int SAT_MAX = 255;  // magnitude ceiling

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    pix_t r;
    pix_t g;
    pix_t b;
  } rgb_t;

  // The coefficients sum to 256, so the 16-bit accumulator never overflows
  // and the top byte is the luma value.
  function automatic pix_t rgb_to_gray(input rgb_t p);
    logic [15:0] acc;
    acc = 16'(COEF_R) * 16'(p.r) + 16'(COEF_G) * 16'(p.g) + 16'(COEF_B) * 16'(p.b);
    return acc[15:8];
  endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: DEPTH-entry, 8-bit delay line with enable.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset (clears contents)
//   en         : advance; when low, contents and pointer hold
//   din        : sample written this enabled cycle
//   dout       : sample written DEPTH enabled cycles ago
// Implemented as a circular buffer: the slot about to be overwritten holds
// exactly the sample from DEPTH enables back, so it is read combinationally.
module line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  pix_t din,
  output pix_t dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pix_t             mem [DEPTH];
  logic [PTR_W-1:0] ptr_reg;

  assign dout = mem[ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (en) begin
      mem[ptr_reg] <= din;
      ptr_reg      <= (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sobel_image_processor.sv
// sobel_image_processor: streaming 3x3 Sobel edge detector.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   shift_en   : pixel valid / advance; low freezes the whole pipeline
//   data_in    : packed {R, G, B} pixel, raster order
//   out_pixel  : {M, M, M}, saturated Sobel magnitude, 3 enabled edges later
// Stages: E1 registers gray + position, E2 updates line buffers / window /
// border flag, E3 registers the magnitude.
module sobel_image_processor
  import sobel_pkg::*;
#(
  parameter int WIDTH      = 100,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    shift_en,
  input  logic [3*DATA_WIDTH-1:0] data_in,
  output logic [3*DATA_WIDTH-1:0] out_pixel
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // ---------------- E1: grayscale and position tagging ----------------
  rgb_t             pix_in;
  pix_t             y_reg;
  logic [COL_W-1:0] col_reg, y_col_reg;
  logic [15:0]      row_reg, y_row_reg;

  assign pix_in = rgb_t'(data_in);

  // col_reg/row_reg point at the next incoming pixel; the y_* copies travel
  // with y_reg so the border test refers to the window's newest pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg     <= '0;
      col_reg   <= '0;
      row_reg   <= '0;
      y_col_reg <= '0;
      y_row_reg <= '0;
    end else if (shift_en) begin
      y_reg     <= rgb_to_gray(pix_in);
      y_col_reg <= col_reg;
      y_row_reg <= row_reg;
      if (col_reg == COL_W'(WIDTH - 1)) begin
        col_reg <= '0;
        row_reg <= (row_reg == 16'hFFFF) ? row_reg : row_reg + 16'd1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // ---------------- E2: line buffers, window, border flag ----------------
  // lb_out[0] is row n-1, lb_out[1] is row n-2 (second buffer fed by first).
  pix_t lb_in  [2];
  pix_t lb_out [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lb
      if (gi == 0) begin : g_head
        assign lb_in[gi] = y_reg;
      end else begin : g_chain
        assign lb_in[gi] = lb_out[gi-1];
      end
      line_buffer #(.DEPTH(WIDTH)) u_line_buffer (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (shift_en),
        .din  (lb_in[gi]),
        .dout (lb_out[gi])
      );
    end
  endgenerate

  // win_reg[row][col]: row 0 oldest line, col 2 newest column.
  pix_t win_reg [3][3];
  logic valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_reg[r][c] <= '0;
        end
      end
      valid_reg <= 1'b0;
    end else if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        win_reg[r][0] <= win_reg[r][1];
        win_reg[r][1] <= win_reg[r][2];
      end
      win_reg[0][2] <= lb_out[1];
      win_reg[1][2] <= lb_out[0];
      win_reg[2][2] <= y_reg;
      // Windows with fewer than three real rows or columns (including ones
      // wrapping across a line end) are suppressed.
      valid_reg <= (y_row_reg >= 16'd2) && (y_col_reg >= COL_W'(2));
    end
  end

  // ---------------- Gradient and magnitude (combinational) ----------------
  logic [9:0]               gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [GRAD_W-1:0] gx, gy;
  logic [9:0]               gx_abs, gy_abs;
  logic [10:0]              mag_sum;
  pix_t                     mag;

  always_comb begin
    gx_pos  = 10'(win_reg[0][2]) + (10'(win_reg[1][2]) << 1) + 10'(win_reg[2][2]);
    gx_neg  = 10'(win_reg[0][0]) + (10'(win_reg[1][0]) << 1) + 10'(win_reg[2][0]);
    gy_pos  = 10'(win_reg[2][0]) + (10'(win_reg[2][1]) << 1) + 10'(win_reg[2][2]);
    gy_neg  = 10'(win_reg[0][0]) + (10'(win_reg[0][1]) << 1) + 10'(win_reg[0][2]);
    gx      = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    gy      = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    gx_abs  = gx[GRAD_W-1] ? 10'(-gx) : gx[9:0];
    gy_abs  = gy[GRAD_W-1] ? 10'(-gy) : gy[9:0];
    mag_sum = 11'(gx_abs) + 11'(gy_abs);
    mag     = (mag_sum > 11'(SAT_MAX)) ? PIX_W'(SAT_MAX) : mag_sum[PIX_W-1:0];
  end

  // ---------------- E3: output register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pixel <= '0;
    end else if (shift_en) begin
      out_pixel <= valid_reg ? {3{mag}} : '0;
    end
  end

endmodule

// File: tb/tb_sobel_image_processor.sv
// Self-checking bench for sobel_image_processor. A reference model computes
// each window's magnitude from the full gray history of the stream and pushes
// it to a queue; once three enabled edges have passed since reset, every
// enabled edge pops one entry and compares it with out_pixel.
module tb_sobel_image_processor;

  localparam int W = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        shift_en;
  logic [23:0] data_in;
  logic [23:0] out_pixel;

  sobel_image_processor #(.WIDTH(W), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .data_in  (data_in),
    .out_pixel(out_pixel)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [23:0] exp_q [$];
  int          gray_hist [$];
  int          m_col, m_row, edges, first_nz;
  logic [23:0] last_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int gray_of(input logic [23:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
  endfunction

  // Present one pixel for one enabled edge; model it and score the output.
  task automatic drive(input logic [23:0] p);
    int k, gx, gy, m;
    int win [3][3];
    logic [23:0] e;
    gray_hist.push_back(gray_of(p));
    k = gray_hist.size() - 1;
    m = 0;
    if (m_row >= 2 && m_col >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] = gray_hist[k - (2 - i) * W - (2 - j)];
      gx = (win[0][2] + 2 * win[1][2] + win[2][2]) - (win[0][0] + 2 * win[1][0] + win[2][0]);
      gy = (win[2][0] + 2 * win[2][1] + win[2][2]) - (win[0][0] + 2 * win[0][1] + win[0][2]);
      m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (m > 255) m = 255;
    end
    exp_q.push_back({3{m[7:0]}});
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      if (m_row < 65535) m_row++;
    end
    data_in  = p;
    shift_en = 1'b1;
    @(posedge clk);
    #1;
    shift_en = 1'b0;
    edges++;
    if (edges >= 3) begin
      e = exp_q.pop_front();
      last_exp = e;
      check_eq("stream", 32'(out_pixel), 32'(e));
      if (first_nz < 0 && out_pixel != 24'h0) first_nz = edges;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    shift_en = 1'b0;
    data_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_out", 32'(out_pixel), 32'h0);
    rst_n = 1'b1;
    exp_q.delete();
    gray_hist.delete();
    m_col    = 0;
    m_row    = 0;
    edges    = 0;
    first_nz = -1;
    last_exp = '0;
  endtask

  function automatic logic [23:0] pix_of(input int kind, input int r, input int c);
    case (kind)
      0:       return (c >= 50) ? 24'hFFFFFF : 24'h000000;  // vertical edge
      1:       return (r >= 5) ? 24'h404040 : 24'h000000;   // horizontal edge
      default: return 24'h808080;                           // flat
    endcase
  endfunction

  // Stream rows*W pixels then 3 drain pixels. stall_idx / rst_idx name the
  // pixel before which a 7-cycle stall or a mid-stream reset is injected.
  task automatic stream_image(input int kind, input int rows, input int stall_idx, input int rst_idx);
    for (int idx = 0; idx < rows * W; idx++) begin
      if (idx == rst_idx) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("reset_async", 32'(out_pixel), 32'h0);
        do_reset();
        return;
      end
      if (idx == stall_idx) begin
        for (int s = 0; s < 7; s++) begin
          data_in = 24'($urandom);
          @(posedge clk);
          #1;
          check_eq("stall_hold", 32'(out_pixel), 32'(last_exp));
        end
      end
      drive(pix_of(kind, idx / W, idx % W));
    end
    repeat (3) drive(24'h000000);
  endtask

  initial begin
    rst_n    = 1'b0;
    shift_en = 1'b0;
    data_in  = '0;

    do_reset();
    drive(24'hFF0000); check_eq("gray_red",   32'(dut.y_reg), 32'd76);
    drive(24'h00FF00); check_eq("gray_green", 32'(dut.y_reg), 32'd149);
    drive(24'h0000FF); check_eq("gray_blue",  32'(dut.y_reg), 32'd28);
    drive(24'hFFFFFF); check_eq("gray_white", 32'(dut.y_reg), 32'd255);
    $display("phase grayscale done: %0d checks", n_checks);

    do_reset();
    stream_image(2, 4, -1, -1);
    $display("phase flat 0x808080 done: %0d checks", n_checks);

    do_reset();
    stream_image(0, 10, -1, -1);
    check_eq("latency_first_nz", 32'(first_nz), 32'(2 * W + 50 + 3));
    $display("phase vertical edge done: %0d checks", n_checks);

    do_reset();
    stream_image(1, 8, -1, -1);
    $display("phase horizontal edge done: %0d checks", n_checks);

    do_reset();
    stream_image(0, 10, 4 * W + 53, -1);
    $display("phase stall done: %0d checks", n_checks);

    do_reset();
    stream_image(0, 10, -1, 3 * W + 54);
    stream_image(0, 10, -1, -1);
    check_eq("latency_after_reset", 32'(first_nz), 32'(2 * W + 50 + 3));
    $display("phase mid-stream reset done: %0d checks", n_checks);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
